// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered valid/ready ALU with iterative shift-add multiply
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_NOT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_ROL = 4'b1010;
    localparam logic [3:0] OP_ROR = 4'b1011;
    localparam logic [3:0] OP_EQ  = 4'b1100;
    localparam logic [3:0] OP_MUL = 4'b1101;

    localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic [WIDTH-1:0]   mx_q, mx_d;
    logic [WIDTH-1:0]   my_q, my_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]   alu_out;
    logic               alu_carry;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] partial;
    logic               out_free;
    logic               accept;

    // Output register can take a new value when empty or being drained this cycle
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = (state_q == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;

    // Single-cycle operations on the live operands
    always_comb begin
        sum_ext   = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        diff_ext  = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        shamt     = x[SHW-1:0];
        alu_out   = '0;
        alu_carry = 1'b0;
        case (ctrl)
            OP_ADD: begin
                alu_out   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_out   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_AND:  alu_out = x & y;
            OP_OR:   alu_out = x | y;
            OP_NOT:  alu_out = ~x;
            OP_XOR:  alu_out = x ^ y;
            OP_NOR:  alu_out = ~(x | y);
            OP_SLL:  alu_out = y << shamt;
            OP_SRL:  alu_out = y >> shamt;
            OP_SRA:  alu_out = {x[WIDTH-1], x[WIDTH-1:1]};
            OP_ROL:  alu_out = {x[WIDTH-2:0], x[WIDTH-1]};
            OP_ROR:  alu_out = {x[0], x[WIDTH-1:1]};
            OP_EQ:   alu_out = {{(WIDTH-1){1'b0}}, (x == y)};
            default: alu_out = '0;
        endcase
    end

    // Shifted multiplicand for the current multiplier bit
    always_comb begin
        partial = {{WIDTH{1'b0}}, mx_q} << cnt_q;
    end

    // Next-state logic for the FSM, multiply datapath and output register
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        mx_d        = mx_q;
        my_d        = my_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ctrl == OP_MUL) begin
                        mx_d    = x;
                        my_d    = y;
                        acc_d   = '0;
                        cnt_d   = '0;
                        busy_d  = 1'b1;
                        state_d = ST_MUL;
                    end else begin
                        out_d       = alu_out;
                        carry_d     = alu_carry;
                        out_valid_d = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (my_q[cnt_q]) begin
                    acc_d = acc_q + partial;
                end
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Hold the finished product until the output register is free
                if (out_free) begin
                    out_d       = acc_q[WIDTH-1:0];
                    carry_d     = |acc_q[2*WIDTH-1:WIDTH];
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset abandons any multiply in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            out_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            mx_q        <= '0;
            my_q        <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            mx_q        <= mx_d;
            my_q        <= my_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out       = out_q;
    assign carry     = carry_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - self-checking bench for alu_seq (WIDTH 8 and 16)
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, carry, busy;
    logic [3:0]  ctrl;
    logic [7:0]  x, y, out;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready, w_carry, w_busy;
    logic [3:0]  w_ctrl;
    logic [15:0] w_x, w_y, w_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] c;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] eo;
        logic       ec;
        int         lat;
    } vec_t;

    vec_t       vt[$];
    logic [8:0] sb[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .ctrl(ctrl), .x(x), .y(y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .carry(carry), .busy(busy)
    );

    alu_seq #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready),
        .ctrl(w_ctrl), .x(w_x), .y(w_y),
        .out_valid(w_out_valid), .out_ready(w_out_ready),
        .out(w_out), .carry(w_carry), .busy(w_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference behaviour for WIDTH=8, returns {carry, out}
    function automatic logic [8:0] model(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  s;
        logic [15:0] p;
        case (c)
            4'h0: begin s = {a[7], a} + {b[7], b}; return s; end
            4'h1: begin s = {a[7], a} - {b[7], b}; return s; end
            4'h2: return {1'b0, a & b};
            4'h3: return {1'b0, a | b};
            4'h4: return {1'b0, ~a};
            4'h5: return {1'b0, a ^ b};
            4'h6: return {1'b0, ~(a | b)};
            4'h7: return {1'b0, b << a[2:0]};
            4'h8: return {1'b0, b >> a[2:0]};
            4'h9: return {1'b0, a[7], a[7:1]};
            4'hA: return {1'b0, a[6:0], a[7]};
            4'hB: return {1'b0, a[0], a[7:1]};
            4'hC: return {8'h00, a == b};
            4'hD: begin p = a * b; return {|p[15:8], p[7:0]}; end
            default: return 9'h000;
        endcase
    endfunction

    // Scoreboard: push on accepted input, pop and compare on consumed output
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    check("sb_result", {23'd0, carry, out}, {23'd0, sb.pop_front()});
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(ctrl, x, y));
            end
        end
    end

    task automatic run_op(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] o, output logic cy, output int lat,
                          output int bc, output int irb);
        int n;
        @(posedge clk);
        #1;
        ctrl = c; x = a; y = b; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ctrl = 4'($urandom); x = 8'($urandom); y = 8'($urandom);
        lat = 1; bc = 0; irb = 0;
        @(negedge clk);
        while (!out_valid && lat < 50) begin
            if (busy) bc++;
            if (in_ready) irb++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        o = out;
        cy = carry;
    endtask

    initial begin
        logic [7:0] o;
        logic       cy;
        int         lat, bc, irb, vcnt, rcnt, n;
        logic [3:0] ops[15];

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ctrl = '0; x = '0; y = '0;
        w_in_valid = 1'b0; w_out_ready = 1'b0; w_ctrl = '0; w_x = '0; w_y = '0;

        vt.push_back('{4'h0, 8'hFE, 8'h01, 8'hFF, 1'b1, 1});
        vt.push_back('{4'h0, 8'h88, 8'h88, 8'h10, 1'b1, 1});
        vt.push_back('{4'h1, 8'h01, 8'h87, 8'h7A, 1'b0, 1});
        vt.push_back('{4'h1, 8'hFE, 8'h01, 8'hFD, 1'b1, 1});
        vt.push_back('{4'h7, 8'hAA, 8'h98, 8'h60, 1'b0, 1});
        vt.push_back('{4'h8, 8'hAA, 8'h98, 8'h26, 1'b0, 1});
        vt.push_back('{4'h9, 8'hAA, 8'h98, 8'hD5, 1'b0, 1});
        vt.push_back('{4'hA, 8'hAA, 8'h98, 8'h55, 1'b0, 1});
        vt.push_back('{4'hB, 8'hAA, 8'h98, 8'h55, 1'b0, 1});
        vt.push_back('{4'h7, 8'h08, 8'hC3, 8'hC3, 1'b0, 1});
        vt.push_back('{4'h8, 8'h0F, 8'h80, 8'h01, 1'b0, 1});
        vt.push_back('{4'hC, 8'h5A, 8'h5A, 8'h01, 1'b0, 1});
        vt.push_back('{4'hE, 8'hFF, 8'hFF, 8'h00, 1'b0, 1});
        vt.push_back('{4'hD, 8'h0F, 8'h11, 8'hFF, 1'b0, 10});
        vt.push_back('{4'hD, 8'hFF, 8'hFF, 8'h01, 1'b1, 10});
        vt.push_back('{4'hD, 8'h00, 8'hFF, 8'h00, 1'b0, 10});

        repeat (2) @(negedge clk);
        check("rst_out", 32'(out), 32'h0);
        check("rst_carry", 32'(carry), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single operations from the vector table
        for (int i = 0; i < vt.size(); i++) begin
            run_op(vt[i].c, vt[i].a, vt[i].b, o, cy, lat, bc, irb);
            check($sformatf("vec%0d_out", i), 32'(o), 32'(vt[i].eo));
            check($sformatf("vec%0d_carry", i), 32'(cy), 32'(vt[i].ec));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
            if (vt[i].c == 4'hD) begin
                check($sformatf("vec%0d_busy_cycles", i), 32'(bc), 32'd9);
                check($sformatf("vec%0d_in_ready_busy", i), 32'(irb), 32'd0);
            end
        end

        // Back-to-back stream, one result per cycle
        for (int i = 0; i < 13; i++) ops[i] = 4'(i);
        ops[13] = 4'hE;
        ops[14] = 4'hF;
        vcnt = 0; rcnt = 0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            ctrl = ops[i]; x = 8'hAA; y = 8'h98; in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) rcnt++;
            if (i > 0 && out_valid) vcnt++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (out_valid) vcnt++;
        check("b2b_accepts", 32'(rcnt), 32'd15);
        check("b2b_results", 32'(vcnt), 32'd15);

        // Backpressure, then same-cycle drain and accept
        @(posedge clk);
        #1 out_ready = 1'b0; ctrl = 4'h2; x = 8'hF0; y = 8'h3C; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_out", 32'(out), 32'h30);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 x = 8'h12; y = 8'h34;
        @(negedge clk);
        check("bp_hold_out", 32'(out), 32'h30);
        check("bp_hold_valid", 32'(out_valid), 32'd1);
        check("bp_hold_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 out_ready = 1'b1; ctrl = 4'h3; x = 8'hF0; y = 8'h0F; in_valid = 1'b1;
        #1 check("bp_same_cycle_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_new_valid", 32'(out_valid), 32'd1);
        check("bp_new_out", 32'(out), 32'hFF);
        @(negedge clk);
        check("bp_drained", 32'(out_valid), 32'd0);

        // WIDTH=16 instance
        @(posedge clk);
        #1 w_ctrl = 4'h0; w_x = 16'hFFFE; w_y = 16'h0001; w_in_valid = 1'b1; w_out_ready = 1'b1;
        @(posedge clk);
        #1 w_in_valid = 1'b0;
        @(negedge clk);
        check("w16_add_valid", 32'(w_out_valid), 32'd1);
        check("w16_add_out", 32'(w_out), 32'hFFFF);
        check("w16_add_carry", 32'(w_carry), 32'd1);
        @(posedge clk);
        #1 w_ctrl = 4'hD; w_x = 16'h0100; w_y = 16'h0100; w_in_valid = 1'b1;
        @(posedge clk);
        #1 w_in_valid = 1'b0; w_x = 16'h1234;
        lat = 1;
        @(negedge clk);
        while (!w_out_valid && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("w16_mul_latency", 32'(lat), 32'd18);
        check("w16_mul_out", 32'(w_out), 32'h0000);
        check("w16_mul_carry", 32'(w_carry), 32'd1);

        // Reset in the middle of a multiply
        @(posedge clk);
        #1 ctrl = 4'hD; x = 8'hFF; y = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out", 32'(out), 32'h0);
        check("rst_mid_carry", 32'(carry), 32'h0);
        check("rst_mid_valid", 32'(out_valid), 32'h0);
        check("rst_mid_busy", 32'(busy), 32'h0);
        sb.delete();
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) n++;
        end
        check("rst_mid_no_result", 32'(n), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
